// File: rtl/accumulator_bank.sv
// accumulator_bank
//   Bank of DEPTH signed accumulators fed one word per cycle (systolic array
//   output side). Words are written in entry order 0..DEPTH-1, either
//   overwriting (mode 0) or adding with saturation (mode 1). A pass ending
//   with acc_last_i on entry DEPTH-1 switches the bank to drain mode, where
//   entries are streamed out in order under valid/ready handshake. Completing
//   the drain clears the bank and re-opens it for filling.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   acc_valid_i  : input word valid (ignored while draining)
//   acc_data_in  : signed input word, DATA_W bits
//   acc_mode_i   : 0 = overwrite entry, 1 = add to entry (saturating)
//   acc_last_i   : final pass marker, only honoured on the entry DEPTH-1 write
//   acc_ready_o  : bank accepts input (fill state)
//   out_valid_o  : drain word valid (drain state)
//   out_ready_i  : downstream accepts drain word
//   out_data_o   : drain word, ACC_W bits signed
//   out_idx_o    : index of drain word
//   out_last_o   : drain word is entry DEPTH-1
//   acc_sat_o    : sticky saturation flag, cleared when a drain completes
module accumulator_bank #(
   parameter int unsigned DEPTH  = 4,
   parameter int          DATA_W = 16,
   parameter int          ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     acc_valid_i,
   input  logic [DATA_W-1:0]        acc_data_in,
   input  logic                     acc_mode_i,
   input  logic                     acc_last_i,
   output logic                     acc_ready_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [ACC_W-1:0]         out_data_o,
   output logic [$clog2(DEPTH)-1:0] out_idx_o,
   output logic                     out_last_o,
   output logic                     acc_sat_o
);

   localparam int unsigned            IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                  state, state_nxt;
   logic signed [ACC_W-1:0] entry [DEPTH];
   logic [IDX_W-1:0]        wr_ptr;
   logic [IDX_W-1:0]        rd_ptr;
   logic                    sat_q;

   logic                    wr_en;
   logic                    rd_xfer;
   logic                    fill_done;
   logic                    drain_done;

   logic signed [ACC_W-1:0] data_ext;
   logic signed [ACC_W-1:0] cur_entry;
   logic signed [ACC_W-1:0] rd_value;
   logic signed [ACC_W-1:0] wr_value;
   logic signed [ACC_W:0]   sum_wide;
   logic                    sum_ovf;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and handshake outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      acc_ready_o = 1'b0;
      out_valid_o = 1'b0;
      wr_en       = 1'b0;
      rd_xfer     = 1'b0;
      fill_done   = 1'b0;
      drain_done  = 1'b0;
      case (state)
         FILL: begin
            acc_ready_o = 1'b1;
            wr_en       = acc_valid_i;
            fill_done   = acc_valid_i && (wr_ptr == LAST_IDX) && acc_last_i;
            if (fill_done) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            out_valid_o = 1'b1;
            rd_xfer     = out_ready_i;
            drain_done  = out_ready_i && (rd_ptr == LAST_IDX);
            if (drain_done) begin
               state_nxt = FILL;
            end
         end
         default: begin
            state_nxt = FILL;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Entry selection for the write and read ports
   // ---------------------------------------------------------------------
   always_comb begin
      cur_entry = '0;
      rd_value  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (wr_ptr == IDX_W'(i)) begin
            cur_entry = entry[i];
         end
         if (rd_ptr == IDX_W'(i)) begin
            rd_value = entry[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Write value: sign-extend, add one bit wider and clamp on overflow.
   // Overflow shows up as the two top bits of the widened sum disagreeing;
   // the top bit then gives the true sign of the result.
   // ---------------------------------------------------------------------
   always_comb begin
      data_ext = ACC_W'($signed(acc_data_in));
      sum_wide = {cur_entry[ACC_W-1], cur_entry} + {data_ext[ACC_W-1], data_ext};
      sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      if (!acc_mode_i) begin
         wr_value = data_ext;
      end else if (sum_ovf) begin
         wr_value = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         wr_value = sum_wide[ACC_W-1:0];
      end
   end

   // ---------------------------------------------------------------------
   // Entries, pointers and sticky saturation flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         sat_q  <= 1'b0;
      end else if (drain_done) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         sat_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (wr_ptr == IDX_W'(i)) begin
                  entry[i] <= wr_value;
               end
            end
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + IDX_W'(1);
            if (acc_mode_i && sum_ovf) begin
               sat_q <= 1'b1;
            end
         end
         if (rd_xfer) begin
            rd_ptr <= rd_ptr + IDX_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Drain outputs (forced to zero outside drain)
   // ---------------------------------------------------------------------
   always_comb begin
      out_data_o = out_valid_o ? rd_value : '0;
      out_idx_o  = rd_ptr;
      out_last_o = out_valid_o && (rd_ptr == LAST_IDX);
      acc_sat_o  = sat_q;
   end

endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank
//   Drives two banks: u_dut with default widths (ACC_W=32) and u_sat with
//   ACC_W=16 so saturation is reachable in a few writes. Expected values come
//   from an array-based model of the bank contents with plain integer
//   arithmetic and clamping.
module tb_accumulator_bank;

   localparam int DEPTH = 4;

   typedef logic signed [63:0] val_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // u_dut signals
   logic        v0, m0, l0, ry0;
   logic [15:0] din0;
   logic        ar0, ov0, ol0, sat0;
   logic [31:0] od0;
   logic [1:0]  oi0;

   // u_sat signals
   logic        v1, m1, l1, ry1;
   logic [15:0] din1;
   logic        ar1, ov1, ol1, sat1;
   logic [15:0] od1;
   logic [1:0]  oi1;

   accumulator_bank #(.DEPTH(DEPTH), .DATA_W(16), .ACC_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .acc_valid_i(v0), .acc_data_in(din0), .acc_mode_i(m0), .acc_last_i(l0),
      .acc_ready_o(ar0), .out_valid_o(ov0), .out_ready_i(ry0),
      .out_data_o(od0), .out_idx_o(oi0), .out_last_o(ol0), .acc_sat_o(sat0)
   );

   accumulator_bank #(.DEPTH(DEPTH), .DATA_W(16), .ACC_W(16)) u_sat (
      .clk(clk), .rst(rst),
      .acc_valid_i(v1), .acc_data_in(din1), .acc_mode_i(m1), .acc_last_i(l1),
      .acc_ready_o(ar1), .out_valid_o(ov1), .out_ready_i(ry1),
      .out_data_o(od1), .out_idx_o(oi1), .out_last_o(ol1), .acc_sat_o(sat1)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: bank contents, next entry, fill/drain, sticky flag
   longint m_e   [2][DEPTH];
   int     m_wp  [2];
   bit     m_fill[2];
   bit     m_sat [2];
   longint m_min [2];
   longint m_max [2];

   task automatic check(string tag, val_t obs, val_t exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic val_t g_ready(int d); return val_t'(d == 0 ? ar0  : ar1);  endfunction
   function automatic val_t g_valid(int d); return val_t'(d == 0 ? ov0  : ov1);  endfunction
   function automatic val_t g_last (int d); return val_t'(d == 0 ? ol0  : ol1);  endfunction
   function automatic val_t g_sat  (int d); return val_t'(d == 0 ? sat0 : sat1); endfunction
   function automatic val_t g_idx  (int d); return val_t'(d == 0 ? oi0  : oi1);  endfunction
   function automatic val_t g_data (int d);
      if (d == 0) return val_t'($signed(od0));
      return val_t'($signed(od1));
   endfunction

   task automatic set_in(int d, logic v, longint data, logic mode, logic last);
      if (d == 0) begin
         v0 = v; din0 = 16'(data); m0 = mode; l0 = last;
      end else begin
         v1 = v; din1 = 16'(data); m1 = mode; l1 = last;
      end
   endtask

   task automatic set_ready(int d, logic r);
      if (d == 0) ry0 = r;
      else        ry1 = r;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < DEPTH; k++) m_e[d][k] = 0;
         m_wp[d]   = 0;
         m_fill[d] = 1'b1;
         m_sat[d]  = 1'b0;
      end
   endtask

   task automatic model_write(int d, longint v, bit mode, bit last);
      longint s;
      if (!m_fill[d]) return;
      if (mode) begin
         s = m_e[d][m_wp[d]] + v;
         if (s > m_max[d]) begin
            s = m_max[d]; m_sat[d] = 1'b1;
         end else if (s < m_min[d]) begin
            s = m_min[d]; m_sat[d] = 1'b1;
         end
         m_e[d][m_wp[d]] = s;
      end else begin
         m_e[d][m_wp[d]] = v;
      end
      if (m_wp[d] == DEPTH - 1) begin
         m_wp[d] = 0;
         if (last) m_fill[d] = 1'b0;
      end else begin
         m_wp[d]++;
      end
   endtask

   // Called #1 after a rising edge; presents one word for the next edge.
   task automatic do_write(int d, longint v, bit mode, bit last, string tag);
      check({tag, "/ready"}, g_ready(d), val_t'(m_fill[d]));
      set_in(d, 1'b1, v, mode, last);
      @(posedge clk);
      model_write(d, v, mode, last);
      #1;
      set_in(d, 1'b0, 0, 1'b0, 1'b0);
      check({tag, "/sat"}, g_sat(d), val_t'(m_sat[d]));
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drains all entries; word stall_k is held back stall_n cycles while a
   // junk input word is offered (it must be ignored).
   task automatic drain_all(int d, int stall_k, int stall_n, string tag);
      longint exp_e[DEPTH];
      for (int k = 0; k < DEPTH; k++) exp_e[k] = m_e[d][k];
      check({tag, "/ready_drain"}, g_ready(d), 0);
      for (int k = 0; k < DEPTH; k++) begin
         check({tag, "/valid"}, g_valid(d), 1);
         check({tag, "/idx"},   g_idx(d),   k);
         check({tag, "/data"},  g_data(d),  exp_e[k]);
         check({tag, "/last"},  g_last(d),  val_t'(k == DEPTH - 1));
         check({tag, "/sat_d"}, g_sat(d),   val_t'(m_sat[d]));
         if (k == stall_k) begin
            set_ready(d, 1'b0);
            set_in(d, 1'b1, 16'h1234, 1'b1, 1'b1);
            repeat (stall_n) begin
               @(posedge clk);
               #1;
               check({tag, "/hold_idx"},  g_idx(d),  k);
               check({tag, "/hold_data"}, g_data(d), exp_e[k]);
               check({tag, "/hold_vld"},  g_valid(d), 1);
            end
            set_in(d, 1'b0, 0, 1'b0, 1'b0);
         end
         set_ready(d, 1'b1);
         @(posedge clk);
         #1;
         set_ready(d, 1'b0);
      end
      for (int k = 0; k < DEPTH; k++) m_e[d][k] = 0;
      m_wp[d]   = 0;
      m_fill[d] = 1'b1;
      m_sat[d]  = 1'b0;
      check({tag, "/ready_after"}, g_ready(d), 1);
      check({tag, "/valid_after"}, g_valid(d), 0);
      check({tag, "/sat_after"},   g_sat(d),   0);
   endtask

   task automatic check_reset_outputs(string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "/rst_ready"}, g_ready(d), 1);
         check({tag, "/rst_valid"}, g_valid(d), 0);
         check({tag, "/rst_data"},  g_data(d),  0);
         check({tag, "/rst_idx"},   g_idx(d),   0);
         check({tag, "/rst_last"},  g_last(d),  0);
         check({tag, "/rst_sat"},   g_sat(d),   0);
      end
   endtask

   // Asserted away from the clock edge so the outputs must react
   // asynchronously, then held across an edge before release.
   task automatic apply_reset(string tag);
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_outputs({tag, "_async"});
      @(posedge clk);
      #1;
      check_reset_outputs({tag, "_held"});
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] r16;
      longint      v;
      int          passes;
      int          d;
      bit          md, lst;

      m_min[0] = -(64'sd1 <<< 31); m_max[0] = (64'sd1 <<< 31) - 1;
      m_min[1] = -(64'sd1 <<< 15); m_max[1] = (64'sd1 <<< 15) - 1;
      set_in(0, 1'b0, 0, 1'b0, 1'b0);
      set_in(1, 1'b0, 0, 1'b0, 1'b0);
      set_ready(0, 1'b0);
      set_ready(1, 1'b0);
      rst = 1'b0;
      model_reset();
      #12;
      check_reset_outputs("por");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single pass, overwrite
      do_write(0, 1, 1'b0, 1'b0, "single");
      do_write(0, 2, 1'b0, 1'b0, "single");
      do_write(0, 3, 1'b0, 1'b0, "single");
      do_write(0, 4, 1'b0, 1'b1, "single");
      drain_all(0, DEPTH, 0, "single");

      // Two passes; last on entry 1 of pass 1 must be ignored; stall at idx 1
      do_write(0, 10, 1'b0, 1'b0, "two");
      do_write(0, 20, 1'b0, 1'b1, "two");
      do_write(0, 30, 1'b0, 1'b0, "two");
      do_write(0, 40, 1'b0, 1'b0, "two");
      check("two/still_fill", g_ready(0), 1);
      do_write(0, 1,  1'b1, 1'b0, "two");
      do_write(0, -2, 1'b1, 1'b0, "two");
      do_write(0, 3,  1'b1, 1'b0, "two");
      do_write(0, -4, 1'b1, 1'b1, "two");
      check("two/e1", val_t'(m_e[0][1]), 18);
      drain_all(0, 1, 3, "two");

      // Saturation at ACC_W=16
      do_write(1, 32767,  1'b0, 1'b0, "sat");
      do_write(1, -32768, 1'b0, 1'b0, "sat");
      do_write(1, 100,    1'b0, 1'b0, "sat");
      do_write(1, 0,      1'b0, 1'b0, "sat");
      do_write(1, 5,      1'b1, 1'b0, "sat");
      check("sat/flag_set", g_sat(1), 1);
      do_write(1, -1,     1'b1, 1'b0, "sat");
      do_write(1, 1,      1'b1, 1'b0, "sat");
      do_write(1, 2,      1'b1, 1'b1, "sat");
      drain_all(1, 2, 2, "sat");

      // Reset mid-fill, then a clean pass
      do_write(0, 5, 1'b0, 1'b0, "rstfill");
      do_write(0, 6, 1'b0, 1'b0, "rstfill");
      apply_reset("rstfill");
      for (int k = 0; k < DEPTH; k++) do_write(0, 7, 1'b0, k == DEPTH - 1, "rstfill");
      drain_all(0, DEPTH, 0, "rstfill");

      // Back-to-back: add onto the cleared bank right after the drain
      do_write(0, 9, 1'b1, 1'b0, "b2b");
      do_write(0, 8, 1'b0, 1'b0, "b2b");
      do_write(0, -7, 1'b0, 1'b0, "b2b");
      do_write(0, 6, 1'b1, 1'b1, "b2b");
      drain_all(0, DEPTH, 0, "b2b");

      // Reset mid-drain discards the pending words
      for (int k = 0; k < DEPTH; k++) do_write(1, 100 + k, 1'b0, k == DEPTH - 1, "rstdrn");
      set_ready(1, 1'b1);
      @(posedge clk);
      #1;
      set_ready(1, 1'b0);
      check("rstdrn/idx1", g_idx(1), 1);
      apply_reset("rstdrn");
      for (int k = 0; k < DEPTH; k++) do_write(1, 3, 1'b1, k == DEPTH - 1, "rstdrn");
      drain_all(1, DEPTH, 0, "rstdrn");

      // Randomized passes on both banks
      for (int r = 0; r < 12; r++) begin
         d      = r % 2;
         passes = $urandom_range(1, 3);
         for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (d == 1) begin
                  if ($urandom_range(0, 1) == 1) v = 32767 - longint'($urandom_range(0, 50));
                  else                           v = -32768 + longint'($urandom_range(0, 50));
               end else begin
                  r16 = 16'($urandom);
                  v   = longint'($signed(r16));
               end
               md  = ($urandom_range(0, 3) != 0);
               if (k == DEPTH - 1) lst = (p == passes - 1);
               else                lst = ($urandom_range(0, 1) == 1);
               do_write(d, v, md, lst, "rand");
               if ($urandom_range(0, 3) == 0) idle(1);
            end
         end
         drain_all(d, $urandom_range(0, DEPTH), $urandom_range(1, 3), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
